write_back_registrada: RTL

//  Registered write-back stage of the MIPS pipeline: MEM/WB latch, load extension, result select.

---
 rtl/mips_defs.sv | 36 +++
 rtl/extensor_load.sv | 36 +++
 rtl/write_back_registrada.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS write-back definitions: source-select and load-type encodings,
// the latched control bundle and the register-index width helper.
package mips_defs;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC8 = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] memto_reg;
    logic [2:0] tipo_load;
  } wb_ctrl_t;

  // Bits needed to hold 'value' (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/extensor_load.sv
// Load extension: picks the addressed byte/halfword from the raw memory word
// (little-endian lanes) and sign- or zero-extends it to the datapath width.
module extensor_load
  import mips_defs::*;
#(
  parameter int D = 32
) (
  input  logic [D-1:0] data_raw,
  input  logic [1:0]   offset,
  input  logic [2:0]   tipo_load,
  output logic [D-1:0] data_ext
);

  // Only the low word is addressable by a 2-bit offset.
  logic [3:0][7:0]  bytes;
  logic [1:0][15:0] halves;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign bytes    = data_raw[31:0];
  assign halves   = data_raw[31:0];
  assign byte_sel = bytes[offset];
  assign half_sel = halves[offset[1]];

  always_comb begin
    data_ext = data_raw;
    case (tipo_load)
      LOAD_LB:  data_ext = {{(D-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data_ext = {{(D-8){1'b0}}, byte_sel};
      LOAD_LH:  data_ext = {{(D-16){half_sel[15]}}, half_sel};
      LOAD_LHU: data_ext = {{(D-16){1'b0}}, half_sel};
      default:  data_ext = data_raw;
    endcase
  end

endmodule

// File: rtl/write_back_registrada.sv
// MEM/WB latch plus write-back: load extension, ALU/MEM/PC+8 select,
// r0-guarded write strobe, sticky halt flag and saturating retire counter.
module write_back_registrada
  import mips_defs::*;
#(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_CONTADOR  = 32,
  localparam int RW = clogb2(CANT_REGISTROS - 1),
  localparam int D  = CANT_BITS_REGISTROS,
  localparam int C  = CANT_BITS_CONTADOR
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic [RW-1:0] i_registro_destino,
  input  logic [D-1:0]  i_data_mem,
  input  logic [D-1:0]  i_data_alu,
  input  logic [D-1:0]  i_pc_mas_8,
  input  logic          i_RegWrite,
  input  logic [1:0]    i_MemtoReg,
  input  logic [2:0]    i_tipo_load,
  input  logic          i_halt,
  output logic [RW-1:0] o_registro_destino,
  output logic          o_RegWrite,
  output logic [D-1:0]  o_data_write,
  output logic          o_halt_detected,
  output logic [C-1:0]  o_instr_retiradas,
  output logic          o_led
);

  localparam logic [C-1:0] CNT_ONE = {{(C-1){1'b0}}, 1'b1};

  wb_ctrl_t      ctrl_q;
  logic [RW-1:0] dest_q;
  logic [D-1:0]  mem_q;
  logic [D-1:0]  alu_q;
  logic [D-1:0]  pc8_q;
  logic          halt_q;
  logic [C-1:0]  cnt_q;
  logic [D-1:0]  load_ext;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      ctrl_q <= '0;
      dest_q <= '0;
      mem_q  <= '0;
      alu_q  <= '0;
      pc8_q  <= '0;
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (i_enable) begin
      ctrl_q <= '{valid: i_valid, reg_write: i_RegWrite,
                  memto_reg: i_MemtoReg, tipo_load: i_tipo_load};
      dest_q <= i_registro_destino;
      mem_q  <= i_data_mem;
      alu_q  <= i_data_alu;
      pc8_q  <= i_pc_mas_8;
      // Flag uses the pre-edge value, so the HALT itself still retires.
      if (i_valid && !halt_q && cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
      if (i_valid && i_halt) halt_q <= 1'b1;
    end
  end

  extensor_load #(.D(D)) u_extensor_load (
    .data_raw  (mem_q),
    .offset    (alu_q[1:0]),
    .tipo_load (ctrl_q.tipo_load),
    .data_ext  (load_ext)
  );

  always_comb begin
    o_data_write = alu_q;
    case (ctrl_q.memto_reg)
      WB_SRC_MEM: o_data_write = load_ext;
      WB_SRC_PC8: o_data_write = pc8_q;
      default:    o_data_write = alu_q;
    endcase
  end

  assign o_registro_destino = dest_q;
  assign o_RegWrite         = ctrl_q.reg_write & ctrl_q.valid & (dest_q != '0);
  assign o_halt_detected    = halt_q;
  assign o_led              = halt_q;
  assign o_instr_retiradas  = cnt_q;

endmodule
